// File: rtl/lsu_mem_port.sv
// ---------------------------------------------------------------------------
// lsu_mem_port
//
// Load/store unit front end for the 16-bit word-addressed data RAM. It takes
// one load or store at a time from the execute stage, decides whether the
// address belongs to the data RAM or to the memory-mapped I/O window, pulses
// exactly one access strobe for one cycle, and hands back a registered
// response.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   req_valid/req_ready        request handshake from the CPU
//   req_we/req_addr/req_wdata  request contents (1 = store, 0 = load)
//   resp_valid/resp_ready      response handshake back to the CPU
//   resp_rdata/resp_is_io      load data (0 for stores) and target flag
//   mem_read/mem_write         data RAM strobes
//   mem_addr/mem_wdata         data RAM address and write data
//   mem_rdata                  data RAM read data (combinational)
//   io_read/io_write           I/O window strobes
//   io_addr/io_wdata           I/O register offset and write data
//   io_rdata                   I/O read data (combinational)
// ---------------------------------------------------------------------------
module lsu_mem_port #(
    parameter logic [15:0] MMIO_BASE = 16'hFF00,
    parameter int          IO_AW     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [15:0]      req_addr,
    input  logic [15:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [15:0]      resp_rdata,
    output logic             resp_is_io,
    output logic             mem_read,
    output logic             mem_write,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    input  logic [15:0]      mem_rdata,
    output logic             io_read,
    output logic             io_write,
    output logic [IO_AW-1:0] io_addr,
    output logic [15:0]      io_wdata,
    input  logic [15:0]      io_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t           state;
    logic             ready_en;
    logic             lat_we;
    logic             lat_is_io;
    logic             handshake;
    logic             req_is_io;
    logic [IO_AW-1:0] io_offset;

    // ready_en is cleared by reset and set on the first clock afterwards, so
    // req_ready stays low for as long as reset is held without feeding the
    // reset net itself into the datapath.
    assign req_ready = ready_en && ((state == IDLE) || ((state == RESP) && resp_ready));
    assign handshake = req_valid && req_ready;
    assign req_is_io = (req_addr >= MMIO_BASE);
    assign io_offset = IO_AW'(req_addr - MMIO_BASE);

    // Single state machine: request capture, the one-cycle access strobe and
    // the response register all live here. The address and write-data outputs
    // only change on a capture, which happens in IDLE or RESP where every
    // strobe is low, so they are stable for the whole strobe cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ready_en   <= 1'b0;
            lat_we     <= 1'b0;
            lat_is_io  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 16'h0000;
            resp_is_io <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= 16'h0000;
            mem_wdata  <= 16'h0000;
            io_read    <= 1'b0;
            io_write   <= 1'b0;
            io_addr    <= '0;
            io_wdata   <= 16'h0000;
        end else begin
            ready_en <= 1'b1;

            if (handshake) begin
                lat_we    <= req_we;
                lat_is_io <= req_is_io;
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
                io_addr   <= io_offset;
                io_wdata  <= req_wdata;
                mem_read  <= !req_is_io && !req_we;
                mem_write <= !req_is_io &&  req_we;
                io_read   <=  req_is_io && !req_we;
                io_write  <=  req_is_io &&  req_we;
            end

            case (state)
                IDLE: begin
                    if (handshake) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_read   <= 1'b0;
                    mem_write  <= 1'b0;
                    io_read    <= 1'b0;
                    io_write   <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_is_io <= lat_is_io;
                    if (lat_we) begin
                        resp_rdata <= 16'h0000;
                    end else if (lat_is_io) begin
                        resp_rdata <= io_rdata;
                    end else begin
                        resp_rdata <= mem_rdata;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        if (req_valid) begin
                            state <= ACCESS;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_port
//
// Bench for lsu_mem_port. A behavioural RAM and I/O responder sit on the
// memory side. A reference model predicts, from each accepted request, which
// strobe must fire, with which address/data, and what response must come
// back; a monitor compares the DUT against it every cycle. Directed tests add
// hand-computed literal expectations on top.
// ---------------------------------------------------------------------------
module tb_lsu_mem_port;

    localparam logic [15:0] MMIO = 16'hFF00;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_rdata;
    logic        resp_is_io;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        io_read;
    logic        io_write;
    logic [7:0]  io_addr;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;

    lsu_mem_port #(
        .MMIO_BASE(MMIO),
        .IO_AW    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_is_io(resp_is_io),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .io_read   (io_read),
        .io_write  (io_write),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata)
    );

    typedef struct {
        logic        we;
        logic        is_io;
        logic [15:0] addr;
        logic [15:0] wdata;
    } acc_t;

    typedef struct {
        logic [15:0] rdata;
        logic        is_io;
    } rsp_t;

    logic [15:0] ram [0:65535];
    logic [15:0] model_ram [0:65535];

    acc_t        acc_q[$];
    rsp_t        resp_q[$];
    int          strobe_cyc[$];
    logic [15:0] resp_log[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mem_read_cnt = 0;
    int          mem_write_cnt = 0;
    int          io_read_cnt = 0;
    int          io_write_cnt = 0;
    int          resp_cnt = 0;
    logic [15:0] last_resp_rdata = 16'h0;
    logic        last_resp_is_io = 1'b0;
    logic [15:0] last_mem_addr = 16'h0;
    logic [15:0] last_mem_wdata = 16'h0;
    logic [7:0]  last_io_addr = 8'h0;
    logic [15:0] last_io_wdata = 16'h0;

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory-side responders: the RAM answers reads combinationally while
    // its strobe is high, the I/O window returns 16'h00AA xor the offset.
    assign mem_rdata = mem_read ? ram[mem_addr] : 16'hDEAD;
    assign io_rdata  = io_read ? (16'h00AA ^ {8'h00, io_addr}) : 16'hDEAD;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 16'(i) ^ 16'hA5A5;
        end
        ram[16'hFEFF] = 16'h1234;
        forever begin
            @(posedge clk);
            if (mem_write) begin
                ram[mem_addr] = mem_wdata;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model plus per-cycle comparison, sampled on the falling edge.
    initial begin
        logic        pend_strobe;
        logic        pend_resp;
        logic        prev_hold;
        logic [15:0] prev_rdata;
        logic        prev_is_io;
        int          nstrobe;
        acc_t        e;
        rsp_t        r;
        logic [15:0] off;
        logic [3:0]  exp_vec;

        pend_strobe = 1'b0;
        pend_resp   = 1'b0;
        prev_hold   = 1'b0;
        prev_rdata  = 16'h0;
        prev_is_io  = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            model_ram[i] = 16'(i) ^ 16'hA5A5;
        end
        model_ram[16'hFEFF] = 16'h1234;

        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                acc_q.delete();
                resp_q.delete();
                pend_strobe = 1'b0;
                pend_resp   = 1'b0;
                prev_hold   = 1'b0;
            end else begin
                nstrobe = int'(mem_read) + int'(mem_write) + int'(io_read) + int'(io_write);
                if (mem_read)  mem_read_cnt++;
                if (mem_write) mem_write_cnt++;
                if (io_read)   io_read_cnt++;
                if (io_write)  io_write_cnt++;

                if (pend_resp) begin
                    checkOutput("resp_latency", 32'(resp_valid), 32'd1);
                    pend_resp = 1'b0;
                end

                if (pend_strobe) begin
                    checkOutput("strobe_count", nstrobe, 1);
                    checkOutput("ready_in_access", 32'(req_ready), 32'd0);
                    if (acc_q.size() > 0) begin
                        e = acc_q.pop_front();
                        exp_vec = e.is_io ? {2'b00, !e.we, e.we} : {!e.we, e.we, 2'b00};
                        checkOutput("strobe_kind", 32'({mem_read, mem_write, io_read, io_write}),
                                    32'(exp_vec));
                        off = e.addr - MMIO;
                        if (e.is_io) begin
                            checkOutput("io_addr", 32'(io_addr), 32'(off[7:0]));
                            if (e.we) checkOutput("io_wdata", 32'(io_wdata), 32'(e.wdata));
                            r.rdata = e.we ? 16'h0000 : (16'h00AA ^ {8'h00, off[7:0]});
                        end else begin
                            checkOutput("mem_addr", 32'(mem_addr), 32'(e.addr));
                            if (e.we) begin
                                checkOutput("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
                                model_ram[e.addr] = e.wdata;
                            end
                            r.rdata = e.we ? 16'h0000 : model_ram[e.addr];
                        end
                        r.is_io = e.is_io;
                        resp_q.push_back(r);
                    end
                    strobe_cyc.push_back(cyc);
                    last_mem_addr  = mem_addr;
                    last_mem_wdata = mem_wdata;
                    last_io_addr   = io_addr;
                    last_io_wdata  = io_wdata;
                    pend_strobe = 1'b0;
                    pend_resp   = 1'b1;
                end else if (nstrobe != 0) begin
                    checkOutput("spurious_strobe", nstrobe, 0);
                end

                if (resp_valid) begin
                    if (prev_hold) begin
                        checkOutput("resp_rdata_stable", 32'(resp_rdata), 32'(prev_rdata));
                        checkOutput("resp_is_io_stable", 32'(resp_is_io), 32'(prev_is_io));
                    end
                    if (resp_ready) begin
                        if (resp_q.size() > 0) begin
                            r = resp_q.pop_front();
                            checkOutput("resp_rdata", 32'(resp_rdata), 32'(r.rdata));
                            checkOutput("resp_is_io", 32'(resp_is_io), 32'(r.is_io));
                        end else begin
                            checkOutput("unexpected_resp", 32'(resp_valid), 32'd0);
                        end
                        last_resp_rdata = resp_rdata;
                        last_resp_is_io = resp_is_io;
                        resp_log.push_back(resp_rdata);
                        resp_cnt++;
                        prev_hold = 1'b0;
                    end else begin
                        prev_hold  = 1'b1;
                        prev_rdata = resp_rdata;
                        prev_is_io = resp_is_io;
                    end
                end else begin
                    prev_hold = 1'b0;
                end

                if (req_valid && req_ready) begin
                    e.we    = req_we;
                    e.addr  = req_addr;
                    e.wdata = req_wdata;
                    e.is_io = (req_addr >= MMIO);
                    acc_q.push_back(e);
                    pend_strobe = 1'b1;
                end
            end
        end
    end

    // Present one request and hold it until it is accepted.
    task automatic applyStimulus(input logic we, input logic [15:0] addr,
                                 input logic [15:0] wdata);
        int   n;
        logic hs;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = req_ready;
            n++;
        end
        if (!hs) checkOutput("handshake_timeout", 32'(hs), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic waitResp(input int target);
        int n;
        n = 0;
        while (resp_cnt < target && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (resp_cnt < target) checkOutput("resp_timeout", resp_cnt, target);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence.
    initial begin
        int   base;
        int   m0;
        int   s0;
        int   n;
        int   nc;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 16'h0;
        req_wdata  = 16'h0;
        resp_ready = 1'b1;

        #3;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_resp", 32'({resp_valid, resp_is_io, resp_rdata}), 32'd0);
        checkOutput("rst_strobes", 32'({mem_read, mem_write, io_read, io_write}), 32'd0);
        checkOutput("rst_mem_bus", {mem_addr, mem_wdata}, 32'd0);
        checkOutput("rst_io_bus", 32'({io_addr, io_wdata}), 32'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_req_ready", 32'(req_ready), 32'd1);

        $display("[TB] store BEEF to 0010, load it back");
        m0 = mem_write_cnt;
        base = resp_cnt;
        applyStimulus(1'b1, 16'h0010, 16'hBEEF);
        waitResp(base + 1);
        checkOutput("store_one_write", mem_write_cnt - m0, 1);
        checkOutput("store_mem_addr", 32'(last_mem_addr), 32'h0010);
        checkOutput("store_mem_wdata", 32'(last_mem_wdata), 32'hBEEF);
        checkOutput("store_resp", 32'({last_resp_is_io, last_resp_rdata}), 32'h0);
        m0 = mem_read_cnt;
        applyStimulus(1'b0, 16'h0010, 16'h0000);
        waitResp(base + 2);
        checkOutput("load_one_read", mem_read_cnt - m0, 1);
        checkOutput("load_rdata", 32'(last_resp_rdata), 32'hBEEF);

        $display("[TB] window boundary loads");
        applyStimulus(1'b0, 16'hFEFF, 16'h0000);
        waitResp(base + 3);
        checkOutput("feff_rdata", 32'(last_resp_rdata), 32'h1234);
        checkOutput("feff_is_io", 32'(last_resp_is_io), 32'd0);
        m0 = io_read_cnt;
        applyStimulus(1'b0, 16'hFF00, 16'h0000);
        waitResp(base + 4);
        checkOutput("ff00_io_read", io_read_cnt - m0, 1);
        checkOutput("ff00_io_addr", 32'(last_io_addr), 32'h00);
        checkOutput("ff00_rdata", 32'(last_resp_rdata), 32'h00AA);
        checkOutput("ff00_is_io", 32'(last_resp_is_io), 32'd1);

        $display("[TB] back-to-back loads 0..3");
        base = resp_cnt;
        req_we    = 1'b0;
        req_wdata = 16'h0;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = 16'(i);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!req_ready && n < 20);
            if (!req_ready) checkOutput("b2b_handshake_timeout", 32'(req_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        waitResp(base + 4);
        nc = strobe_cyc.size();
        for (int i = 1; i < 4; i++) begin
            checkOutput("b2b_strobe_spacing",
                        strobe_cyc[nc - 4 + i] - strobe_cyc[nc - 5 + i], 2);
        end
        nc = resp_log.size();
        checkOutput("b2b_resp0", 32'(resp_log[nc - 4]), 32'hA5A5);
        checkOutput("b2b_resp1", 32'(resp_log[nc - 3]), 32'hA5A4);
        checkOutput("b2b_resp2", 32'(resp_log[nc - 2]), 32'hA5A7);
        checkOutput("b2b_resp3", 32'(resp_log[nc - 1]), 32'hA5A6);

        $display("[TB] response backpressure");
        base = resp_cnt;
        resp_ready = 1'b0;
        applyStimulus(1'b0, 16'h0020, 16'h0000);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 20);
        if (!resp_valid) checkOutput("bp_resp_timeout", 32'(resp_valid), 32'd1);
        @(posedge clk);
        #1;
        req_we    = 1'b0;
        req_addr  = 16'h0021;
        req_valid = 1'b1;
        s0 = mem_read_cnt + mem_write_cnt + io_read_cnt + io_write_cnt;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_resp_valid", 32'(resp_valid), 32'd1);
            checkOutput("bp_resp_rdata", 32'(resp_rdata), 32'hA585);
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
        end
        checkOutput("bp_no_strobes",
                    mem_read_cnt + mem_write_cnt + io_read_cnt + io_write_cnt - s0, 0);
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        waitResp(base + 2);
        checkOutput("bp_second_rdata", 32'(last_resp_rdata), 32'hA584);

        $display("[TB] reset during a store access");
        req_we    = 1'b1;
        req_addr  = 16'h0030;
        req_wdata = 16'h7777;
        req_valid = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("mid_rst_strobe_up", 32'(mem_write), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_strobes", 32'({mem_read, mem_write, io_read, io_write}), 32'd0);
        checkOutput("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_ready", 32'(req_ready), 32'd1);
        checkOutput("post_rst_resp_valid", 32'(resp_valid), 32'd0);
        base = resp_cnt;
        applyStimulus(1'b0, 16'h0030, 16'h0000);
        waitResp(base + 1);
        checkOutput("lost_write_rdata", 32'(last_resp_rdata), 32'hA595);

        $display("[TB] store 5A5A to FFFF");
        base = resp_cnt;
        m0 = mem_write_cnt;
        s0 = io_write_cnt;
        applyStimulus(1'b1, 16'hFFFF, 16'h5A5A);
        waitResp(base + 1);
        checkOutput("ffff_io_write", io_write_cnt - s0, 1);
        checkOutput("ffff_no_mem_write", mem_write_cnt - m0, 0);
        checkOutput("ffff_io_addr", 32'(last_io_addr), 32'h00FF);
        checkOutput("ffff_io_wdata", 32'(last_io_wdata), 32'h5A5A);
        checkOutput("ffff_resp", 32'({last_resp_is_io, last_resp_rdata}), 32'h10000);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit sitting directly upstream of the 16-bit word-addressed data RAM.
- Accepts one load or store request at a time from the CPU execute stage over a valid/ready handshake.
- Steers the request to the data RAM or to the memory-mapped I/O window, and returns a registered response.
- The data RAM has a synchronous write and a combinational read gated by its read strobe. This block asserts exactly one strobe for exactly one cycle per access.

Parameters:
- MMIO_BASE, 16'hFF00, first word address of the I/O window; addresses >= MMIO_BASE go to I/O, all lower addresses go to RAM.
- IO_AW, 8, width of io_addr; io_addr = (req_addr - MMIO_BASE)[IO_AW-1:0].

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU presents a request
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  16  word address
- req_wdata  in  16  store data
- resp_valid  out  1  response available
- resp_ready  in  1  CPU consumes response
- resp_rdata  out  16  load data; 16'h0000 for stores
- resp_is_io  out  1  response came from the I/O window
- mem_read  out  1  data RAM read strobe
- mem_write  out  1  data RAM write strobe
- mem_addr  out  16  data RAM address
- mem_wdata  out  16  data RAM write data
- mem_rdata  in  16  data RAM read data, valid combinationally while mem_read=1
- io_read  out  1  I/O read strobe
- io_write  out  1  I/O write strobe
- io_addr  out  IO_AW  I/O register offset
- io_wdata  out  16  I/O write data
- io_rdata  in  16  I/O read data, valid combinationally while io_read=1

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset state: IDLE.
- Reset values:
  - req_ready=0 during reset, then 1 in IDLE.
  - resp_valid=0, resp_rdata=0, resp_is_io=0.
  - All strobes 0; mem_addr, mem_wdata, io_addr and io_wdata = 0.
- req_ready = 1 in IDLE, and 1 in RESP when resp_ready=1. It is 0 in ACCESS.
- Request capture:
  - On a handshake (req_valid & req_ready), latch we, addr, wdata and the decode flag is_io = (addr >= MMIO_BASE).
  - Next state: ACCESS.
- ACCESS (exactly 1 cycle):
  - RAM target: mem_read = ~we, mem_write = we.
  - I/O target: io_read = ~we, io_write = we.
  - Exactly one strobe is high; strobes are low in every other state.
  - Address and write-data outputs are driven from the latched values and hold them until the next capture. They must never change while a strobe is high.
  - At the end of the cycle, capture resp_rdata = load ? (is_io ? io_rdata : mem_rdata) : 16'h0000, and set resp_is_io = is_io.
  - Next state: RESP.
- RESP:
  - resp_valid=1, and resp_rdata/resp_is_io are held stable until resp_ready=1.
  - On resp_ready=1 with req_valid=1: the new request is captured in the same cycle and the next state is ACCESS (back-to-back; 2 cycles per access).
  - On resp_ready=1 with req_valid=0: next state IDLE, resp_valid drops the next cycle.
- Latency: request accepted at edge N; strobe high during cycle N+1; resp_valid high from cycle N+2.
- Boundaries:
  - Address MMIO_BASE-1 goes to RAM; MMIO_BASE goes to I/O; 16'hFFFF goes to I/O with io_addr = 16'hFFFF - MMIO_BASE truncated to IO_AW bits.
  - req_valid while in ACCESS is ignored (req_ready=0); the CPU holds it.
  - Asynchronous reset mid-ACCESS drops every strobe immediately. A write whose edge has not yet occurred is lost, and no response is produced.
  - resp_ready asserted in IDLE or ACCESS has no effect.

Test Plan:
- Store 16'hBEEF to 16'h0010, then load 16'h0010:
  - Store: mem_write high for exactly one cycle with mem_addr=16'h0010, mem_wdata=16'hBEEF; response has resp_rdata=0, resp_is_io=0.
  - Load: mem_read high for one cycle; resp_rdata=16'hBEEF.
- Load 16'hFEFF (RAM, preloaded 16'h1234) and 16'hFF00 (io_rdata=16'h00AA):
  - First: mem_read, resp_rdata=16'h1234, resp_is_io=0.
  - Second: io_read, io_addr=0, resp_rdata=16'h00AA, resp_is_io=1.
- Back-to-back: req_valid and resp_ready held high, 4 loads to addresses 0..3 -> one strobe every 2 cycles; responses return in order with the correct data.
- Backpressure: resp_ready held low 5 cycles -> resp_valid and resp_rdata stable, req_ready=0, no extra strobes; on release the next request is accepted the same cycle.
- Reset mid-operation: assert rst_n=0 during the ACCESS cycle of a store -> strobes low immediately; after release, FSM in IDLE, resp_valid=0, req_ready=1.
- Store 16'h5A5A to 16'hFFFF -> io_write for one cycle, io_addr=8'hFF, io_wdata=16'h5A5A, mem_write never high.
